// File: rtl/audioqsys_led_sequencer.sv
// rtl/audioqsys_led_sequencer.sv - Avalon-MM master that animates the red-LED PIO from a tick timer
// CSR slave: 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS; master writes go to PIO data register 0.
module audioqsys_led_sequencer #(
  parameter int LED_WIDTH    = 18,
  parameter int DIV_WIDTH    = 24,
  parameter int RESET_PERIOD = 5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic [4:0]  level,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_TICK,
    S_WRITE,
    S_CLEAR
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BAR    = 2'b11;
  localparam logic       DIR_LEFT    = 1'b0;
  localparam logic       DIR_RIGHT   = 1'b1;

  state_t               state_q, state_d;
  logic                 enable_q, enable_d;
  logic [1:0]           mode_q, mode_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d;
  logic [DIV_WIDTH-1:0] period_m1;
  logic [LED_WIDTH-1:0] pattern_q, pattern_d;
  logic [LED_WIDTH-1:0] cur_q, cur_d;
  logic [LED_WIDTH-1:0] next_pat, bar_pat;
  logic                 dir_q, dir_d, next_dir;
  logic                 reload_q, reload_d;
  logic                 csr_wr, busy, tick, accept;
  logic                 unused_wdata;

  assign csr_wr       = s_chipselect & ~s_write_n;
  assign busy         = (state_q != S_IDLE);
  assign accept       = ~m_waitrequest;
  assign unused_wdata = ^s_writedata;

  // PERIOD of 0 behaves as 1; >= lets a shrunk PERIOD fire on the next cycle.
  assign period_m1 = (period_q == '0) ? '0 : period_q - DIV_WIDTH'(1);
  assign tick      = (timer_q >= period_m1);

  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    if (csr_wr) begin
      case (s_address)
        2'd0: begin
          enable_d = s_writedata[0];
          mode_d   = s_writedata[2:1];
        end
        2'd1:    period_d  = s_writedata[DIV_WIDTH-1:0];
        2'd2:    pattern_d = s_writedata[LED_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // A new seed written while running forces a reload once any in-flight write is accepted.
  assign reload_d = (reload_q && !(state_q inside {S_IDLE, S_LOAD}))
                  || (csr_wr && (s_address == 2'd2) && busy);

  always_comb begin
    for (int i = 0; i < LED_WIDTH; i++) begin
      bar_pat[i] = (int'(level) > i);
    end
    next_pat = cur_q;
    next_dir = dir_q;
    case (mode_q)
      MODE_STATIC: next_pat = cur_q;
      MODE_ROTATE: next_pat = {cur_q[LED_WIDTH-2:0], cur_q[LED_WIDTH-1]};
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          next_pat = cur_q << 1;
          if (next_pat[LED_WIDTH-1]) next_dir = DIR_RIGHT;
        end else begin
          next_pat = cur_q >> 1;
          if (next_pat[0]) next_dir = DIR_LEFT;
        end
      end
      MODE_BAR:    next_pat = bar_pat;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (enable_q) state_d = S_LOAD;
      S_LOAD: state_d = enable_q ? S_WRITE : S_CLEAR;
      S_WAIT_TICK: begin
        if (!enable_q)     state_d = S_CLEAR;
        else if (reload_q) state_d = S_LOAD;
        else if (tick)     state_d = S_WRITE;
      end
      S_WRITE: begin
        if (accept) begin
          if (!enable_q)     state_d = S_CLEAR;
          else if (reload_q) state_d = S_LOAD;
          else               state_d = S_WAIT_TICK;
        end
      end
      S_CLEAR: if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_d   = cur_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    case (state_q)
      S_LOAD: begin
        cur_d   = pattern_q;
        dir_d   = DIR_LEFT;
        timer_d = '0;
      end
      S_WAIT_TICK: begin
        if (enable_q && !reload_q) begin
          if (tick) begin
            cur_d   = next_pat;
            dir_d   = next_dir;
            timer_d = '0;
          end else begin
            timer_d = timer_q + DIV_WIDTH'(1);
          end
        end
      end
      S_CLEAR: if (accept) cur_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    m_address    = 2'b00;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    case (state_q)
      S_WRITE: begin
        m_chipselect               = 1'b1;
        m_write_n                  = 1'b0;
        m_writedata[LED_WIDTH-1:0] = cur_q;
      end
      S_CLEAR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      2'd0: s_readdata[2:0]           = {mode_q, enable_q};
      2'd1: s_readdata[DIV_WIDTH-1:0] = period_q;
      2'd2: s_readdata[LED_WIDTH-1:0] = pattern_q;
      default: begin
        s_readdata[LED_WIDTH-1:0] = cur_q;
        s_readdata[31]            = busy;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q  <= 1'b0;
      mode_q    <= MODE_STATIC;
      period_q  <= DIV_WIDTH'(RESET_PERIOD);
      pattern_q <= '0;
      cur_q     <= '0;
      dir_q     <= DIR_LEFT;
      timer_q   <= '0;
      reload_q  <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
    end
  end

endmodule
